// File: rtl/sensor_scan_ctrl.sv
// Scan sequencer for the four baggage height sensors on a shared bus: settle, capture each
// channel, register the averaged height and pair-fault flag, then offer it over valid/ready.
module sensor_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] sensor_bus,
    output logic [1:0] sel,
    output logic       sample_en,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    input  logic [7:0] height_in,
    output logic [7:0] height,
    output logic       fault,
    output logic       busy,
    output logic       result_valid,
    input  logic       result_ready
);

    typedef enum logic [2:0] {StIdle, StSettle, StCapture, StEval, StHold} state_e;

    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES);

    state_e     state;
    logic [1:0] channel;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= StIdle;
            channel      <= 2'd0;
            cnt          <= 8'd0;
            sel          <= 2'd0;
            sample_en    <= 1'b0;
            sensor1      <= 8'd0;
            sensor2      <= 8'd0;
            sensor3      <= 8'd0;
            sensor4      <= 8'd0;
            height       <= 8'd0;
            fault        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StSettle;
                        channel   <= 2'd0;
                        cnt       <= SettleLoad;
                        sel       <= 2'd0;
                        sample_en <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StSettle: begin
                    // A load of 0 or 1 both leave after a single settle cycle.
                    if (cnt < 8'd2) begin
                        state <= StCapture;
                    end
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StCapture: begin
                    unique case (channel)
                        2'd0: sensor1 <= sensor_bus;
                        2'd1: sensor2 <= sensor_bus;
                        2'd2: sensor3 <= sensor_bus;
                        2'd3: sensor4 <= sensor_bus;
                    endcase
                    if (channel == 2'd3) begin
                        state     <= StEval;
                        sel       <= 2'd0;
                        sample_en <= 1'b0;
                    end else begin
                        state   <= StSettle;
                        channel <= channel + 2'd1;
                        sel     <= channel + 2'd1;
                        cnt     <= SettleLoad;
                    end
                end
                StEval: begin
                    height       <= height_in;
                    fault        <= ((sensor1 == 8'd0) || (sensor3 == 8'd0)) &&
                                    ((sensor2 == 8'd0) || (sensor4 == 8'd0));
                    result_valid <= 1'b1;
                    state        <= StHold;
                end
                StHold: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Runs two controllers (settle 3 and settle 0) against a scan-level model of readings,
// handshake latency and held results.
module tb_sensor_scan_ctrl;

    localparam int SetA = 3;
    localparam int SetB = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [2];
    logic       rdy_v [2];
    logic [7:0] bus_v [2];
    logic [1:0] sel_v [2];
    logic       sen_v [2];
    logic [7:0] sens [2][4];
    logic [7:0] hin [2];
    logic [7:0] hgt [2];
    logic       flt [2];
    logic       busy_v [2];
    logic       val_v [2];

    logic [7:0] rd [4];
    logic [7:0] prev_h [2];
    logic       prev_f [2];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sensor_scan_ctrl #(.SETTLE_CYCLES(SetA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sensor_bus(bus_v[0]), .sel(sel_v[0]),
        .sample_en(sen_v[0]), .sensor1(sens[0][0]), .sensor2(sens[0][1]),
        .sensor3(sens[0][2]), .sensor4(sens[0][3]), .height_in(hin[0]), .height(hgt[0]),
        .fault(flt[0]), .busy(busy_v[0]), .result_valid(val_v[0]), .result_ready(rdy_v[0])
    );

    sensor_scan_ctrl #(.SETTLE_CYCLES(SetB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sensor_bus(bus_v[1]), .sel(sel_v[1]),
        .sample_en(sen_v[1]), .sensor1(sens[1][0]), .sensor2(sens[1][1]),
        .sensor3(sens[1][2]), .sensor4(sens[1][3]), .height_in(hin[1]), .height(hgt[1]),
        .fault(flt[1]), .busy(busy_v[1]), .result_valid(val_v[1]), .result_ready(rdy_v[1])
    );

    // Sensor bus follows the selected channel; averaging unit is mean of the four registers.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bus_v[i] = rd[sel_v[i]];
            hin[i] = 8'((10'(sens[i][0]) + 10'(sens[i][1]) + 10'(sens[i][2])
                         + 10'(sens[i][3])) >> 2);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int i);
        int s;
        s = (i == 0) ? SetA : SetB;
        return (s < 1) ? 1 : s;
    endfunction

    task automatic check_zero(input int i);
        check("rst_sel", 32'(sel_v[i]), 0);
        check("rst_sample_en", 32'(sen_v[i]), 0);
        for (int k = 0; k < 4; k++) check("rst_sensor", 32'(sens[i][k]), 0);
        check("rst_height", 32'(hgt[i]), 0);
        check("rst_fault", 32'(flt[i]), 0);
        check("rst_busy", 32'(busy_v[i]), 0);
        check("rst_valid", 32'(val_v[i]), 0);
    endtask

    task automatic run_scan(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                            input logic [7:0] r3, input int delay, input bit rand_start);
        int         first_v [2];
        int         vcnt [2];
        int         hist [2][4];
        int         last_sel [2];
        bit         done [2];
        bit         closed [2];
        logic [7:0] eh;
        logic       ef;
        rd[0] = r0; rd[1] = r1; rd[2] = r2; rd[3] = r3;
        eh = 8'((10'(r0) + 10'(r1) + 10'(r2) + 10'(r3)) / 4);
        ef = ((r0 == 0) || (r2 == 0)) && ((r1 == 0) || (r3 == 0));
        for (int i = 0; i < 2; i++) begin
            first_v[i] = -1; vcnt[i] = 0; last_sel[i] = 0; done[i] = 0; closed[i] = 0;
            for (int k = 0; k < 4; k++) hist[i][k] = 0;
        end
        @(negedge clk);
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        rdy_v[0] = 1'b0; rdy_v[1] = 1'b0;
        for (int c = 1; c < 80 && !(closed[0] && closed[1]); c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start_v[i] = 1'b0;
                rdy_v[i] = 1'b0;
                if (closed[i]) continue;
                if (done[i]) begin
                    check("idle_busy", 32'(busy_v[i]), 0);
                    check("idle_valid", 32'(val_v[i]), 0);
                    check("idle_sample_en", 32'(sen_v[i]), 0);
                    closed[i] = 1;
                    continue;
                end
                check("busy", 32'(busy_v[i]), 1);
                if (sen_v[i]) begin
                    hist[i][sel_v[i]]++;
                    check("sel_order", 32'(int'(sel_v[i]) >= last_sel[i]), 1);
                    last_sel[i] = int'(sel_v[i]);
                end
                if (val_v[i]) begin
                    if (first_v[i] < 0) first_v[i] = c;
                    check("hold_height", 32'(hgt[i]), 32'(eh));
                    check("hold_fault", 32'(flt[i]), 32'(ef));
                    if (vcnt[i] >= delay) begin
                        rdy_v[i] = 1'b1;
                        done[i] = 1;
                    end
                    vcnt[i]++;
                    if (rand_start) start_v[i] = 1'($urandom_range(1));
                end else begin
                    check("pre_eval_height", 32'(hgt[i]), 32'(prev_h[i]));
                    check("pre_eval_fault", 32'(flt[i]), 32'(prev_f[i]));
                    if (rand_start && $urandom_range(3) == 0) start_v[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            int s;
            s = settle_of(i);
            check("scan_timeout", 32'(closed[i]), 1);
            check("valid_latency", 32'(first_v[i]), 32'(2 + 4 * (s + 1)));
            check("valid_cycles", 32'(vcnt[i]), 32'(delay + 1));
            for (int k = 0; k < 4; k++) begin
                check("chan_dwell", 32'(hist[i][k]), 32'(s + 1));
                check("sensor_reg", 32'(sens[i][k]), 32'(rd[k]));
            end
            prev_h[i] = eh;
            prev_f[i] = ef;
        end
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; rdy_v[i] = 1'b0; prev_h[i] = 8'd0; prev_f[i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) rd[k] = 8'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;

        run_scan(8'd40, 8'd42, 8'd44, 8'd46, 0, 0);
        run_scan(8'd0, 8'd50, 8'd60, 8'd52, 0, 0);
        run_scan(8'd0, 8'd50, 8'd60, 8'd0, 5, 1);

        // Abort a scan during channel 2 settle of the slow controller.
        rd[0] = 8'd11; rd[1] = 8'd22; rd[2] = 8'd33; rd[3] = 8'd44;
        @(negedge clk);
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0; start_v[1] = 1'b0;
            if (sen_v[0] && sel_v[0] == 2'd2) seen = 1;
        end
        check("reach_chan2", 32'(seen), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prev_h[i] = 8'd0; prev_f[i] = 1'b0;
        end

        // Back-to-back random scans, zero readings likely.
        for (int n = 0; n < 8; n++) begin
            logic [7:0] v [4];
            for (int k = 0; k < 4; k++)
                v[k] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(255));
            run_scan(v[0], v[1], v[2], v[3], int'($urandom_range(4)), 1);
        end

        repeat (3) @(negedge clk);
        check("final_busy_a", 32'(busy_v[0]), 0);
        check("final_busy_b", 32'(busy_v[1]), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
